alu_issue_wb: RTL and testbench

- Operand-fetch and writeback stage that sits directly upstream and downstream of the structural 32-bit ALU (ALU_str).
- Accepts 16-bit register-register instructions through a valid/ready handshake and reads operands from an internal 8 x N register file.
- Drives the ALU a/b/c_in/ALUOp inputs, captures overall_out/c_out, and writes the result back to the register file.
- Also provides a preload port and a debug read port so benches can initialise and inspect state.

---
 rtl/alu_issue_wb.sv | 158 +++++++++++++++
 tb/tb_alu_issue_wb.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_wb.sv
// Operand-fetch and writeback stage wrapped around an external 32-bit ALU.
// Owns an 8-entry register file, issues one register-register instruction
// every four cycles, and writes the ALU result back to the destination.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an instruction; preload port is active here
// FETCH | read R[rs]/R[rt] into the ALU operand registers
// EXEC  | ALU settles; result (and carry for ADD/SUB) sampled at edge
// WB    | wb_valid pulse, R[rd] written at the end of the cycle
module alu_issue_wb #(
    parameter int N    = 32,
    parameter int REGS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [15:0]  instr,
    input  logic         ld_en,
    input  logic [2:0]   ld_addr,
    input  logic [N-1:0] ld_data,
    input  logic [2:0]   dbg_addr,
    output logic [N-1:0] dbg_data,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic         alu_c_in,
    output logic [2:0]   alu_op,
    input  logic [N-1:0] alu_result,
    input  logic         alu_c_out,
    output logic         wb_valid,
    output logic [2:0]   wb_addr,
    output logic [N-1:0] wb_data,
    output logic         carry_flag,
    output logic         illegal_op,
    output logic         busy
);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic         accept;
    logic         accept_ill;
    logic [2:0]   op_q;
    logic [2:0]   rd_q;
    logic [2:0]   rs_q;
    logic [2:0]   rt_q;
    logic [N-1:0] result_q;
    logic [N-1:0] regs [REGS];
    logic         unused_instr_bits;

    // Low instruction bits carry no meaning for this stage.
    assign unused_instr_bits = ^instr[3:0];

    // Preload has priority over issue, so the handshake is closed while ld_en is high.
    assign instr_ready = (state_q == S_IDLE) && !ld_en;
    assign accept      = instr_valid && instr_ready;
    assign accept_ill  = accept && (instr[15:13] == OP_ILL);
    assign busy        = (state_q != S_IDLE);

    assign wb_valid    = (state_q == S_WB);
    assign wb_addr     = wb_valid ? rd_q : 3'd0;
    assign wb_data     = wb_valid ? result_q : '0;

    assign dbg_data    = (dbg_addr == 3'd0) ? '0 : regs[dbg_addr];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; illegal ops are dropped without leaving IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && !accept_ill) state_d = S_FETCH;
            S_FETCH: state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Latch instruction fields on accept and flag illegal ops for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= 3'd0;
            rd_q       <= 3'd0;
            rs_q       <= 3'd0;
            rt_q       <= 3'd0;
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= accept_ill;
            if (accept) begin
                op_q <= instr[15:13];
                rd_q <= instr[12:10];
                rs_q <= instr[9:7];
                rt_q <= instr[6:4];
            end
        end
    end

    // Operand registers feeding the ALU; held from EXEC through WB until the next FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= 3'd0;
            alu_c_in <= 1'b0;
        end else if (state_q == S_FETCH) begin
            alu_a    <= regs[rs_q];
            alu_b    <= regs[rt_q];
            alu_op   <= op_q;
            alu_c_in <= (op_q == OP_SUB);
        end
    end

    // Capture the ALU result, and the carry only for arithmetic ops.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q   <= '0;
            carry_flag <= 1'b0;
        end else if (state_q == S_EXEC) begin
            result_q <= alu_result;
            if (op_q == OP_ADD || op_q == OP_SUB) begin
                carry_flag <= alu_c_out;
            end
        end
    end

    // Register file: preload in IDLE, writeback at the end of WB; R0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state_q == S_IDLE && ld_en) begin
            if (ld_addr != 3'd0) regs[ld_addr] <= ld_data;
        end else if (state_q == S_WB) begin
            if (rd_q != 3'd0) regs[rd_q] <= result_q;
        end
    end

endmodule

// File: tb/tb_alu_issue_wb.sv
module tb_alu_issue_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_c_in, alu_c_out;
    logic [2:0]  alu_op;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;
    logic        carry_flag, illegal_op, busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl [8];
    logic        mdl_carry;
    logic [32:0] alu_s;

    always #10 clk = ~clk;

    alu_issue_wb #(.N(32), .REGS(8)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in), .alu_op(alu_op),
        .alu_result(alu_result), .alu_c_out(alu_c_out),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .carry_flag(carry_flag), .illegal_op(illegal_op), .busy(busy)
    );

    // Stand-in for the structural ALU: a + ~b + c_in style adder.
    always_comb begin
        alu_s      = '0;
        alu_result = '0;
        alu_c_out  = 1'b0;
        case (alu_op)
            3'd0: alu_result = alu_a;
            3'd1: alu_result = ~alu_a;
            3'd2: begin
                alu_s = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_c_in};
                alu_result = alu_s[31:0];
                alu_c_out  = alu_s[32];
            end
            3'd3: begin
                alu_s = {1'b0, alu_a} + {1'b0, ~alu_b} + {32'd0, alu_c_in};
                alu_result = alu_s[31:0];
                alu_c_out  = alu_s[32];
            end
            3'd4: alu_result = alu_a | alu_b;
            3'd5: alu_result = alu_a & alu_b;
            3'd6: begin
                alu_s = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_result = {31'd0, alu_s[31] ^ ((alu_a[31] ^ alu_b[31]) & (alu_a[31] ^ alu_s[31]))};
            end
            default: alu_result = '0;
        endcase
    end

    // Reference: {carry, result} from plain arithmetic on the operand values.
    function automatic logic [32:0] ref_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return {1'b0, a};
            3'd1: return {1'b0, ~a};
            3'd2: return {1'b0, a} + {1'b0, b};
            3'd3: return {(a >= b), a - b};
            3'd4: return {1'b0, a | b};
            3'd5: return {1'b0, a & b};
            3'd6: return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
            default: return 33'd0;
        endcase
    endfunction

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            checks++;
            if (dbg_data !== mdl[i]) begin
                errors++;
                $display("FAIL %s_reg%0d got=%h exp=%h", tag, i, dbg_data, mdl[i]);
            end
        end
    endtask

    task automatic load_reg(input logic [2:0] addr, input logic [31:0] data);
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        instr_valid = 1'($urandom_range(0, 1));
        instr = 16'($urandom);
        #1;
        checks++;
        if (instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_ready got=%b exp=0", instr_ready);
        end
        @(posedge clk); #1;
        ld_en = 1'b0; instr_valid = 1'b0;
        checks++;
        if ({busy, illegal_op} !== 2'b00) begin
            errors++;
            $display("FAIL load_no_accept busy=%b illegal=%b exp=00", busy, illegal_op);
        end
        if (addr != 3'd0) mdl[addr] = data;
        dbg_addr = addr;
        #1;
        checks++;
        if (dbg_data !== mdl[addr]) begin
            errors++;
            $display("FAIL load_value r%0d got=%h exp=%h", addr, dbg_data, mdl[addr]);
        end
    endtask

    task automatic run_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
        logic [31:0] a, b;
        logic [32:0] r;
        int n;
        a = mdl[rs]; b = mdl[rt];
        r = ref_exec(op, a, b);
        instr = {op, rd, rs, rt, 4'($urandom)};
        instr_valid = 1'b1;
        #1;
        n = 0;
        while (!instr_ready && n < 10) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout ready=%b exp=1", instr_ready);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        checks++;
        if ({busy, instr_ready, wb_valid} !== 3'b100) begin
            errors++;
            $display("FAIL fetch_status busy/ready/wb got=%b exp=100", {busy, instr_ready, wb_valid});
        end
        @(posedge clk); #1;
        checks++;
        if ({alu_a, alu_b, alu_op, alu_c_in} !== {a, b, op, (op == 3'd3)}) begin
            errors++;
            $display("FAIL alu_drive a=%h b=%h op=%0d cin=%b exp a=%h b=%h op=%0d cin=%b",
                     alu_a, alu_b, alu_op, alu_c_in, a, b, op, (op == 3'd3));
        end
        checks++;
        if ({wb_valid, instr_ready} !== 2'b00) begin
            errors++;
            $display("FAIL exec_status wb/ready got=%b exp=00", {wb_valid, instr_ready});
        end
        @(posedge clk); #1;
        checks++;
        if ({wb_valid, wb_addr, wb_data} !== {1'b1, rd, r[31:0]}) begin
            errors++;
            $display("FAIL wb got v=%b addr=%0d data=%h exp v=1 addr=%0d data=%h",
                     wb_valid, wb_addr, wb_data, rd, r[31:0]);
        end
        if (op == 3'd2 || op == 3'd3) mdl_carry = r[32];
        if (rd != 3'd0) mdl[rd] = r[31:0];
        @(posedge clk); #1;
        checks++;
        if ({busy, wb_valid, carry_flag, instr_ready} !== {1'b0, 1'b0, mdl_carry, 1'b1}) begin
            errors++;
            $display("FAIL post_wb busy/wb/carry/ready got=%b exp=%b",
                     {busy, wb_valid, carry_flag, instr_ready}, {1'b0, 1'b0, mdl_carry, 1'b1});
        end
        dbg_addr = rd;
        #1;
        checks++;
        if (dbg_data !== mdl[rd]) begin
            errors++;
            $display("FAIL wb_reg r%0d got=%h exp=%h", rd, dbg_data, mdl[rd]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; instr_valid = 1'b0; instr = '0; ld_en = 1'b0;
        ld_addr = '0; ld_data = '0; dbg_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({alu_a, alu_b, alu_op, alu_c_in, wb_valid, wb_addr, wb_data, carry_flag, illegal_op, busy, instr_ready}
            !== {32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs a=%h b=%h op=%0d wb=%b data=%h carry=%b ill=%b busy=%b ready=%b",
                     alu_a, alu_b, alu_op, wb_valid, wb_data, carry_flag, illegal_op, busy, instr_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        mdl_carry = 1'b0;
        @(posedge clk); #1;
        check_all_regs("reset");
    endtask

    task automatic test_preload_sub;
        load_reg(3'd1, 32'hfae34b91);
        load_reg(3'd2, 32'h2ba8b508);
        run_instr(3'd3, 3'd3, 3'd1, 3'd2);
        dbg_addr = 3'd3; #1;
        checks++;
        if (dbg_data !== 32'hcf3a9689) begin
            errors++;
            $display("FAIL sub_r3 got=%h exp=cf3a9689", dbg_data);
        end
    endtask

    task automatic test_add_carry;
        load_reg(3'd1, 32'hffffffff);
        load_reg(3'd2, 32'h0000000a);
        run_instr(3'd2, 3'd4, 3'd1, 3'd2);
        dbg_addr = 3'd4; #1;
        checks++;
        if ({dbg_data, carry_flag} !== {32'h00000009, 1'b1}) begin
            errors++;
            $display("FAIL add_carry r4=%h carry=%b exp 00000009 1", dbg_data, carry_flag);
        end
        run_instr(3'd4, 3'd5, 3'd1, 3'd2);
        checks++;
        if (carry_flag !== 1'b1) begin
            errors++;
            $display("FAIL or_keeps_carry got=%b exp=1", carry_flag);
        end
    endtask

    task automatic test_or_r0;
        load_reg(3'd1, 32'hfae34b91);
        load_reg(3'd2, 32'h2ba8b508);
        run_instr(3'd4, 3'd0, 3'd1, 3'd2);
        dbg_addr = 3'd0; #1;
        checks++;
        if (dbg_data !== 32'd0) begin
            errors++;
            $display("FAIL r0_write got=%h exp=00000000", dbg_data);
        end
        run_instr(3'd0, 3'd5, 3'd0, 3'd3);
        dbg_addr = 3'd5; #1;
        checks++;
        if (dbg_data !== 32'd0) begin
            errors++;
            $display("FAIL mov_r0 r5=%h exp=00000000", dbg_data);
        end
    endtask

    task automatic test_back_to_back;
        logic [32:0] r1, r2;
        int acc1, acc2;
        load_reg(3'd1, $urandom);
        load_reg(3'd2, $urandom);
        r1 = ref_exec(3'd2, mdl[1], mdl[2]);
        acc1 = -1; acc2 = -1;
        instr = {3'd2, 3'd6, 3'd1, 3'd2, 4'h0};
        instr_valid = 1'b1;
        #1;
        for (int k = 0; k < 20 && acc2 < 0; k++) begin
            if (acc1 >= 0 && k > acc1 && k < acc1 + 4) begin
                checks++;
                if ({instr_ready, busy} !== 2'b01) begin
                    errors++;
                    $display("FAIL b2b_hold cyc=%0d ready/busy=%b exp=01", k - acc1, {instr_ready, busy});
                end
            end
            if (acc1 >= 0 && k == acc1 + 3) begin
                checks++;
                if ({wb_valid, wb_addr, wb_data} !== {1'b1, 3'd6, r1[31:0]}) begin
                    errors++;
                    $display("FAIL b2b_wb1 v=%b addr=%0d data=%h exp 1 6 %h", wb_valid, wb_addr, wb_data, r1[31:0]);
                end
            end
            if (instr_valid && instr_ready) begin
                if (acc1 < 0) acc1 = k;
                else acc2 = k;
            end
            @(posedge clk); #1;
            if (acc1 == k) instr = {3'd4, 3'd7, 3'd6, 3'd1, 4'h0};
            if (acc2 == k) instr_valid = 1'b0;
        end
        instr_valid = 1'b0;
        checks++;
        if (acc1 < 0 || acc2 < 0 || acc2 - acc1 != 4) begin
            errors++;
            $display("FAIL b2b_spacing got=%0d exp=4", acc2 - acc1);
            return;
        end
        mdl[6] = r1[31:0];
        mdl_carry = r1[32];
        r2 = ref_exec(3'd4, mdl[6], mdl[1]);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({wb_valid, wb_addr, wb_data} !== {1'b1, 3'd7, r2[31:0]}) begin
            errors++;
            $display("FAIL b2b_wb2 v=%b addr=%0d data=%h exp 1 7 %h", wb_valid, wb_addr, wb_data, r2[31:0]);
        end
        mdl[7] = r2[31:0];
        @(posedge clk); #1;
        check_all_regs("b2b");
    endtask

    task automatic test_illegal;
        load_reg(3'd3, $urandom);
        instr = {3'b111, 3'd3, 3'd1, 3'd2, 4'h5};
        instr_valid = 1'b1;
        #1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        checks++;
        if ({illegal_op, busy, wb_valid, instr_ready} !== 4'b1001) begin
            errors++;
            $display("FAIL illegal_pulse ill/busy/wb/ready got=%b exp=1001", {illegal_op, busy, wb_valid, instr_ready});
        end
        @(posedge clk); #1;
        checks++;
        if ({illegal_op, wb_valid} !== 2'b00) begin
            errors++;
            $display("FAIL illegal_end ill/wb got=%b exp=00", {illegal_op, wb_valid});
        end
        check_all_regs("illegal");
    endtask

    task automatic test_reset_midop;
        int wb_seen;
        load_reg(3'd1, 32'hffffffff);
        load_reg(3'd2, 32'h00000003);
        instr = {3'd2, 3'd4, 3'd1, 3'd2, 4'h0};
        instr_valid = 1'b1;
        #1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({alu_a, alu_b, alu_op, alu_c_in, wb_valid, wb_addr, wb_data, carry_flag, illegal_op, busy, instr_ready}
            !== {32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL midop_reset a=%h b=%h op=%0d wb=%b carry=%b busy=%b ready=%b",
                     alu_a, alu_b, alu_op, wb_valid, carry_flag, busy, instr_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        mdl_carry = 1'b0;
        wb_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (wb_valid !== 1'b0) wb_seen++;
        end
        checks++;
        if (wb_seen != 0) begin
            errors++;
            $display("FAIL midop_no_wb got=%0d exp=0", wb_seen);
        end
        check_all_regs("midop");
    endtask

    task automatic test_random;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) < 3) begin
                load_reg(3'($urandom), $urandom);
            end else begin
                run_instr(3'($urandom_range(0, 6)), 3'($urandom), 3'($urandom), 3'($urandom));
            end
        end
        check_all_regs("random");
    endtask

    initial begin
        test_reset();
        test_preload_sub();
        test_add_carry();
        test_or_r0();
        test_back_to_back();
        test_illegal();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
